// File: rtl/dm_access_pkg.sv
// Shared types and constants for the data-memory access controller.
package dm_access_pkg;

  // FSM state encoding
  typedef logic [1:0] state_t;
  localparam state_t IDLE   = 2'd0;
  localparam state_t SETUP  = 2'd1;
  localparam state_t ACCESS = 2'd2;
  localparam state_t DONE   = 2'd3;

  // Requester identifiers
  localparam logic PORT_CPU = 1'b0;
  localparam logic PORT_DBG = 1'b1;

  // Default geometry and timing
  localparam int unsigned DATA_W_DEF  = 8;
  localparam int unsigned ADDR_W_DEF  = 8;
  localparam int unsigned RD_WAIT_DEF = 2;
  localparam int unsigned WR_HOLD_DEF = 4;

  // Down-counter width: large enough to hold the longer of the two access times
  function automatic int unsigned cnt_width(input int unsigned rd_wait,
                                            input int unsigned wr_hold);
    return $clog2((rd_wait > wr_hold) ? rd_wait : wr_hold) + 1;
  endfunction

  localparam int unsigned CNT_W_DEF = cnt_width(RD_WAIT_DEF, WR_HOLD_DEF);

endpackage

// File: rtl/dm_access_pick.sv
// Two-way requester arbiter. Fixed priority (port 0 first) by default;
// round-robin on ties when DM_ACCESS_RR_EN is defined.
module dm_access_pick
  import dm_access_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] req,
  input  logic       grant_en,
  output logic       win_id_c,
  output logic       win_valid_c,
  output logic       gnt_id,
  output logic       gnt_valid
);

`ifdef DM_ACCESS_RR_EN
  logic prefer;

  // Winner selection: on a tie the port not granted last wins
  always_comb begin
    win_valid_c = grant_en && (req != 2'b00);
    win_id_c    = PORT_CPU;
    if (req == 2'b11)
      win_id_c = prefer;
    else if (req[1])
      win_id_c = PORT_DBG;
  end

  // Round-robin pointer moves only when a grant is issued
  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      prefer <= PORT_CPU;
    else if (win_valid_c)
      prefer <= ~win_id_c;
  end
`else
  // Winner selection: port 0 always beats port 1
  always_comb begin
    win_valid_c = grant_en && (req != 2'b00);
    win_id_c    = PORT_CPU;
    if (!req[0] && req[1])
      win_id_c = PORT_DBG;
  end
`endif

  // Registered grant: gnt_id holds the owner of the current access
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      gnt_id    <= PORT_CPU;
      gnt_valid <= 1'b0;
    end else begin
      gnt_valid <= win_valid_c;
      if (win_valid_c)
        gnt_id <= win_id_c;
    end
  end

endmodule

// File: rtl/dm_access_ctrl.sv
// Data-memory access controller: shares one 8-bit memory between the CPU
// (port 0) and debug/DMA (port 1), sequencing setup, strobe and ack.
// Optional feature macro: DM_ACCESS_RR_EN (round-robin tie breaking).
module dm_access_ctrl
  import dm_access_pkg::*;
#(
  parameter int unsigned DATA_W  = DATA_W_DEF,
  parameter int unsigned ADDR_W  = ADDR_W_DEF,
  parameter int unsigned RD_WAIT = RD_WAIT_DEF,
  parameter int unsigned WR_HOLD = WR_HOLD_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              p0_req,
  input  logic              p0_we,
  input  logic [ADDR_W-1:0] p0_addr,
  input  logic [DATA_W-1:0] p0_wdata,
  output logic              p0_ack,
  output logic [DATA_W-1:0] p0_rdata,
  input  logic              p1_req,
  input  logic              p1_we,
  input  logic [ADDR_W-1:0] p1_addr,
  input  logic [DATA_W-1:0] p1_wdata,
  output logic              p1_ack,
  output logic [DATA_W-1:0] p1_rdata,
  output logic              mem_read,
  output logic              mem_write,
  output logic [ADDR_W-1:0] mem_abus,
  output logic [DATA_W-1:0] mem_din,
  input  logic [DATA_W-1:0] mem_databus,
  output logic              busy
);

  localparam int unsigned CNT_W = cnt_width(RD_WAIT, WR_HOLD);

  state_t             state, state_d;
  logic [CNT_W-1:0]   cnt, cnt_d;
  logic               we_q, we_d;
  logic [ADDR_W-1:0]  abus_d;
  logic [DATA_W-1:0]  din_d;
  logic [DATA_W-1:0]  rdata0_d, rdata1_d;
  logic               rd_d, wr_d, busy_d, ack0_d, ack1_d;
  logic               win_id_c, win_valid_c, gnt_id, gnt_valid;

  dm_access_pick u_pick (
    .clk         (clk),
    .reset       (reset),
    .req         ({p1_req, p0_req}),
    .grant_en    (state == IDLE),
    .win_id_c    (win_id_c),
    .win_valid_c (win_valid_c),
    .gnt_id      (gnt_id),
    .gnt_valid   (gnt_valid)
  );

  // Next-state, latched request fields and next values of registered outputs
  always_comb begin
    state_d  = state;
    cnt_d    = cnt;
    we_d     = we_q;
    abus_d   = mem_abus;
    din_d    = mem_din;
    rdata0_d = p0_rdata;
    rdata1_d = p1_rdata;

    case (state)
      IDLE: begin
        if (win_valid_c) begin
          state_d = SETUP;
          if (win_id_c == PORT_DBG) begin
            we_d   = p1_we;
            abus_d = p1_addr;
            din_d  = p1_wdata;
          end else begin
            we_d   = p0_we;
            abus_d = p0_addr;
            din_d  = p0_wdata;
          end
        end
      end
      SETUP: begin
        if (gnt_valid) begin
          state_d = ACCESS;
          cnt_d   = we_q ? CNT_W'(WR_HOLD) : CNT_W'(RD_WAIT);
        end else begin
          state_d = IDLE;
        end
      end
      ACCESS: begin
        if (cnt == CNT_W'(1)) begin
          state_d = DONE;
          if (!we_q) begin
            if (gnt_id == PORT_DBG)
              rdata1_d = mem_databus;
            else
              rdata0_d = mem_databus;
          end
        end else begin
          cnt_d = cnt - CNT_W'(1);
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase

    rd_d   = (state_d == ACCESS) && !we_d;
    wr_d   = (state_d == ACCESS) && we_d;
    busy_d = (state_d != IDLE);
    ack0_d = (state_d == DONE) && (gnt_id == PORT_CPU);
    ack1_d = (state_d == DONE) && (gnt_id == PORT_DBG);
  end

  // State, counter, latches and all outputs; reset drops strobes immediately
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      cnt       <= '0;
      we_q      <= 1'b0;
      mem_abus  <= '0;
      mem_din   <= '0;
      mem_read  <= 1'b0;
      mem_write <= 1'b0;
      busy      <= 1'b0;
      p0_ack    <= 1'b0;
      p1_ack    <= 1'b0;
      p0_rdata  <= '0;
      p1_rdata  <= '0;
    end else begin
      state     <= state_d;
      cnt       <= cnt_d;
      we_q      <= we_d;
      mem_abus  <= abus_d;
      mem_din   <= din_d;
      mem_read  <= rd_d;
      mem_write <= wr_d;
      busy      <= busy_d;
      p0_ack    <= ack0_d;
      p1_ack    <= ack1_d;
      p0_rdata  <= rdata0_d;
      p1_rdata  <= rdata1_d;
    end
  end

endmodule

// File: tb/tb_dm_access_ctrl.sv
// Self-checking bench for dm_access_ctrl: directed latency/strobe tests,
// arbitration, reset abort, and a random two-port stream against a memory model.
module tb_dm_access_ctrl;

  logic clk;
  logic reset;
  logic mem_clr;

  // DUT A: default timing
  logic       a_p0_req, a_p0_we, a_p1_req, a_p1_we;
  logic [7:0] a_p0_addr, a_p0_wdata, a_p1_addr, a_p1_wdata;
  logic       a_p0_ack, a_p1_ack, a_mem_read, a_mem_write, a_busy;
  logic [7:0] a_p0_rdata, a_p1_rdata, a_mem_abus, a_mem_din, a_mem_databus;

  // DUT B: RD_WAIT=1, WR_HOLD=1
  logic       b_p0_req, b_p0_we, b_p1_req, b_p1_we;
  logic [7:0] b_p0_addr, b_p0_wdata, b_p1_addr, b_p1_wdata;
  logic       b_p0_ack, b_p1_ack, b_mem_read, b_mem_write, b_busy;
  logic [7:0] b_p0_rdata, b_p1_rdata, b_mem_abus, b_mem_din, b_mem_databus;

  logic [7:0] mem_a [256];
  logic [7:0] mem_b [256];
  logic [7:0] ref_mem [256];

  int checks = 0;
  int errors = 0;

  // Observation mux for the port-0 directed task
  logic       sel_b;
  wire        obs_ack   = sel_b ? b_p0_ack   : a_p0_ack;
  wire [7:0]  obs_rdata = sel_b ? b_p0_rdata : a_p0_rdata;
  wire        obs_rd    = sel_b ? b_mem_read : a_mem_read;
  wire        obs_wr    = sel_b ? b_mem_write : a_mem_write;
  wire [7:0]  obs_abus  = sel_b ? b_mem_abus : a_mem_abus;
  wire [7:0]  obs_din   = sel_b ? b_mem_din  : a_mem_din;
  wire        obs_busy  = sel_b ? b_busy     : a_busy;

  dm_access_ctrl u_dut_a (
    .clk(clk), .reset(reset),
    .p0_req(a_p0_req), .p0_we(a_p0_we), .p0_addr(a_p0_addr), .p0_wdata(a_p0_wdata),
    .p0_ack(a_p0_ack), .p0_rdata(a_p0_rdata),
    .p1_req(a_p1_req), .p1_we(a_p1_we), .p1_addr(a_p1_addr), .p1_wdata(a_p1_wdata),
    .p1_ack(a_p1_ack), .p1_rdata(a_p1_rdata),
    .mem_read(a_mem_read), .mem_write(a_mem_write), .mem_abus(a_mem_abus),
    .mem_din(a_mem_din), .mem_databus(a_mem_databus), .busy(a_busy)
  );

  dm_access_ctrl #(.RD_WAIT(1), .WR_HOLD(1)) u_dut_b (
    .clk(clk), .reset(reset),
    .p0_req(b_p0_req), .p0_we(b_p0_we), .p0_addr(b_p0_addr), .p0_wdata(b_p0_wdata),
    .p0_ack(b_p0_ack), .p0_rdata(b_p0_rdata),
    .p1_req(b_p1_req), .p1_we(b_p1_we), .p1_addr(b_p1_addr), .p1_wdata(b_p1_wdata),
    .p1_ack(b_p1_ack), .p1_rdata(b_p1_rdata),
    .mem_read(b_mem_read), .mem_write(b_mem_write), .mem_abus(b_mem_abus),
    .mem_din(b_mem_din), .mem_databus(b_mem_databus), .busy(b_busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural memories: write on strobe, read data visible while mem_read is high
  always @(posedge clk) begin
    if (mem_clr) begin
      for (int i = 0; i < 256; i++) mem_a[i] <= 8'h00;
    end else if (a_mem_write) begin
      mem_a[a_mem_abus] <= a_mem_din;
    end
    if (b_mem_write) mem_b[b_mem_abus] <= b_mem_din;
  end
  assign a_mem_databus = a_mem_read ? mem_a[a_mem_abus] : 8'h00;
  assign b_mem_databus = b_mem_read ? mem_b[b_mem_abus] : 8'h00;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic pulse_reset();
    @(negedge clk); reset = 1'b1;
    @(negedge clk); reset = 1'b0;
  endtask

  // One port-0 access on DUT A or B; cycle 0 is the cycle the request is raised
  task automatic do_single(input bit use_b, input bit we, input logic [7:0] addr,
                           input logic [7:0] wdata, input int exp_ack, input int exp_strb,
                           input logic [7:0] exp_rd, input string tag);
    int ack_at, strb, wrong, unstable;
    ack_at = -1; strb = 0; wrong = 0; unstable = 0;
    sel_b = use_b;
    @(negedge clk);
    if (use_b) begin
      b_p0_we = we; b_p0_addr = addr; b_p0_wdata = wdata; b_p0_req = 1'b1;
    end else begin
      a_p0_we = we; a_p0_addr = addr; a_p0_wdata = wdata; a_p0_req = 1'b1;
    end
    for (int k = 1; k <= 40 && ack_at < 0; k++) begin
      @(negedge clk);
      if (we ? obs_wr : obs_rd) strb++;
      if (we ? obs_rd : obs_wr) wrong++;
      if (k == 1 && (obs_rd || obs_wr)) wrong++;
      if (obs_abus !== addr || (we && obs_din !== wdata)) unstable++;
      if (obs_ack) begin
        ack_at = k;
        if (obs_rd || obs_wr) wrong++;
        if (use_b) b_p0_req = 1'b0; else a_p0_req = 1'b0;
      end
    end
    if (use_b) b_p0_req = 1'b0; else a_p0_req = 1'b0;
    chk({tag, "_ack_cycle"}, 32'(ack_at), 32'(exp_ack));
    chk({tag, "_strobe_cycles"}, 32'(strb), 32'(exp_strb));
    chk({tag, "_bad_strobe"}, 32'(wrong), 32'd0);
    chk({tag, "_bus_unstable"}, 32'(unstable), 32'd0);
    if (!we) chk({tag, "_rdata"}, 32'(obs_rdata), 32'(exp_rd));
    @(negedge clk);
    chk({tag, "_busy_after"}, 32'(obs_busy), 32'd0);
  endtask

  // Random accesses from one port of DUT A; each port owns half the address space
  task automatic run_port(input bit port, input int nops, output int acked);
    logic [7:0] addr, wd;
    bit we;
    int got;
    acked = 0;
    for (int i = 0; i < nops; i++) begin
      repeat ($urandom_range(0, 3) + 1) @(negedge clk);
      we   = 1'($urandom_range(0, 1));
      addr = {port, 7'($urandom_range(0, 127))};
      wd   = 8'($urandom);
      if (port) begin
        a_p1_we = we; a_p1_addr = addr; a_p1_wdata = wd; a_p1_req = 1'b1;
      end else begin
        a_p0_we = we; a_p0_addr = addr; a_p0_wdata = wd; a_p0_req = 1'b1;
      end
      got = 0;
      for (int k = 0; k < 200 && got == 0; k++) begin
        @(negedge clk);
        if (port ? a_p1_ack : a_p0_ack) got = 1;
      end
      if (port) a_p1_req = 1'b0; else a_p0_req = 1'b0;
      chk($sformatf("rnd_p%0d_op%0d_acked", port, i), 32'(got), 32'd1);
      if (got == 1) begin
        acked++;
        if (!we)
          chk($sformatf("rnd_p%0d_op%0d_rdata", port, i),
              32'(port ? a_p1_rdata : a_p0_rdata), 32'(ref_mem[addr]));
        else
          ref_mem[addr] = wd;
      end
    end
  endtask

  initial begin
    int hits, n, acked0, acked1;
    int lp[3], lc[3], ep[3], ec[3];

    reset = 1'b1; mem_clr = 1'b1; sel_b = 1'b0;
    a_p0_req = 0; a_p0_we = 0; a_p0_addr = 0; a_p0_wdata = 0;
    a_p1_req = 0; a_p1_we = 0; a_p1_addr = 0; a_p1_wdata = 0;
    b_p0_req = 0; b_p0_we = 0; b_p0_addr = 0; b_p0_wdata = 0;
    b_p1_req = 0; b_p1_we = 0; b_p1_addr = 0; b_p1_wdata = 0;
    repeat (3) @(negedge clk);
    mem_clr = 1'b0;

    // Reset state: every output low
    chk("reset_ctrl", 32'({a_p0_ack, a_p1_ack, a_mem_read, a_mem_write, a_busy}), 32'd0);
    chk("reset_data", 32'({a_mem_abus, a_mem_din, a_p0_rdata, a_p1_rdata}), 32'd0);
    chk("reset_b", 32'({b_busy, b_mem_read, b_mem_write, b_mem_abus}), 32'd0);
    reset = 1'b0;

    // Test 1/2: write then read back on port 0
    do_single(1'b0, 1'b1, 8'h10, 8'hA5, 6, 4, 8'h00, "t1_wr");
    do_single(1'b0, 1'b0, 8'h10, 8'h00, 4, 2, 8'hA5, "t2_rd");

    // Test 3: tie between both ports, port 0 re-requests after its first ack
    pulse_reset();
`ifdef DM_ACCESS_RR_EN
    ep = '{0, 1, 0}; ec = '{4, 9, 14};
`else
    ep = '{0, 0, 1}; ec = '{4, 9, 14};
`endif
    @(negedge clk);
    a_p0_we = 0; a_p0_addr = 8'h10; a_p0_req = 1'b1;
    a_p1_we = 0; a_p1_addr = 8'h10; a_p1_req = 1'b1;
    n = 0; hits = 0;
    for (int k = 1; k <= 40 && n < 3; k++) begin
      @(negedge clk);
      if (a_p0_ack && n < 3) begin
        lp[n] = 0; lc[n] = k; n++; hits++;
        if (hits == 2) a_p0_req = 1'b0;
      end
      if (a_p1_ack && n < 3) begin
        lp[n] = 1; lc[n] = k; n++; a_p1_req = 1'b0;
      end
    end
    a_p0_req = 1'b0; a_p1_req = 1'b0;
    chk("t3_ack_count", 32'(n), 32'd3);
    for (int i = 0; i < 3 && i < n; i++) begin
      chk($sformatf("t3_grant%0d_port", i), 32'(lp[i]), 32'(ep[i]));
      chk($sformatf("t3_grant%0d_cycle", i), 32'(lc[i]), 32'(ec[i]));
    end
    chk("t3_p0_rdata", 32'(a_p0_rdata), 32'h A5);
    chk("t3_p1_rdata", 32'(a_p1_rdata), 32'h A5);

    // Test 4: reset during the second write ACCESS cycle
    @(negedge clk); @(negedge clk);
    a_p0_we = 1; a_p0_addr = 8'h44; a_p0_wdata = 8'h3C; a_p0_req = 1'b1;
    repeat (3) @(negedge clk);
    chk("t4_write_active", 32'(a_mem_write), 32'd1);
    reset = 1'b1;
    #1;
    chk("t4_async_drop", 32'({a_mem_write, a_mem_read, a_busy, a_p0_ack}), 32'd0);
    a_p0_req = 1'b0;
    @(negedge clk); reset = 1'b0;
    hits = 0;
    repeat (10) begin
      @(negedge clk);
      if (a_p0_ack || a_p1_ack || a_busy || a_mem_write || a_mem_read) hits++;
    end
    chk("t4_no_ack_idle", 32'(hits), 32'd0);

    // Test 5a: idle bench, nothing may move
    hits = 0;
    repeat (20) begin
      @(negedge clk);
      if (a_mem_read || a_mem_write || a_busy || b_mem_read || b_mem_write || b_busy) hits++;
    end
    chk("t5_idle_quiet", 32'(hits), 32'd0);

    // Test 6: shortest timing
    do_single(1'b1, 1'b1, 8'h33, 8'h5C, 3, 1, 8'h00, "t6_wr");
    do_single(1'b1, 1'b0, 8'h33, 8'h00, 3, 1, 8'h5C, "t6_rd");
    sel_b = 1'b0;

    // Test 5b: random stream from both ports against the reference array
    @(negedge clk); mem_clr = 1'b1;
    @(negedge clk); mem_clr = 1'b0;
    for (int i = 0; i < 256; i++) ref_mem[i] = 8'h00;
    fork
      run_port(1'b0, 25, acked0);
      run_port(1'b1, 25, acked1);
    join
    chk("rnd_p0_all_acked", 32'(acked0), 32'd25);
    chk("rnd_p1_all_acked", 32'(acked1), 32'd25);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
